word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 111 +++++++++++
 tb/tb_word_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Parallel-to-serial word shifter with ready/valid intake and back-to-back support.
// All serial-side outputs are registered; din_ready depends only on state and R.
module word_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             R,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             busy,
  output logic             last,
  output logic [15:0]      tx_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic [15:0]      count_q, count_d;
  logic             at_last;
  logic             accept;

  // Bit index tracks the bit currently on out, so the final bit is the
  // cycle in which a new word may be taken without a gap.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      out_q   <= IDLE_BIT;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    last_d  = last_q;
    count_d = count_q + {15'd0, last_q};

    at_last   = (state_q == SHIFT) && (idx_q == IDX_MAX);
    din_ready = ~R && ((state_q == IDLE) || at_last);
    accept    = din_valid && din_ready;

    // The first bit goes straight to out; the shift register keeps the rest.
    if (accept) begin
      state_d = SHIFT;
      idx_d   = '0;
      busy_d  = 1'b1;
      last_d  = 1'b0;
      if (MSB_FIRST) begin
        out_d   = din[WIDTH-1];
        shreg_d = din << 1;
      end else begin
        out_d   = din[0];
        shreg_d = din >> 1;
      end
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d = IDLE;
        idx_d   = '0;
        out_d   = IDLE_BIT;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d  = idx_q + 1'b1;
        last_d = ((idx_q + 1'b1) == IDX_MAX);
        if (MSB_FIRST) begin
          out_d   = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end else begin
          out_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign last     = last_q;
  assign tx_count = count_q;

endmodule

// File: tb/tb_word_serializer.sv
// Randomized scoreboard bench for word_serializer: words expand to an expected
// bit queue that a negedge monitor drains against the serial output.
module tb_word_serializer;

  logic        clk;
  logic        R;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        out;
  logic        busy;
  logic        last;
  logic [15:0] tx_count;

  logic [7:0]  din2;
  logic        valid2;
  logic        ready2;
  logic        out2;
  logic        busy2;
  logic        last2;
  logic [15:0] count2;

  typedef struct packed {
    logic b;
    logic isLast;
  } bitExp_t;

  bitExp_t     expQ[$];
  logic [15:0] modelCount;
  logic        monOn;
  int          total;
  int          bad;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .R(R), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .out(out), .busy(busy), .last(last), .tx_count(tx_count)
  );

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .R(R), .din(din2), .din_valid(valid2), .din_ready(ready2),
    .out(out2), .busy(busy2), .last(last2), .tx_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer a word and wait for the handshake; the word's bits join the model queue.
  task automatic applyStimulus(input logic [7:0] w);
    int budget;
    budget = 0;
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    #2;
    while (!din_ready && budget < 40) begin
      @(negedge clk);
      #2;
      budget++;
    end
    if (!din_ready) begin
      checkOutput("accept_timeout", 32'(din_ready), 32'd1);
    end else begin
      for (int i = 0; i < 8; i++) begin
        expQ.push_back('{b: w[7-i], isLast: (i == 7)});
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 8'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    idleCycles(1);
    while (expQ.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (expQ.size() > 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    bitExp_t e;
    logic    endOfWord;
    endOfWord = 1'b0;
    if (monOn) begin
      if (expQ.size() > 0) begin
        if (!busy) begin
          checkOutput("busy_gap", 32'(busy), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_bit", 32'(out), 32'(e.b));
          checkOutput("last_flag", 32'(last), 32'(e.isLast));
          checkOutput("ready_shift", 32'(din_ready), 32'(e.isLast));
          endOfWord = e.isLast;
        end
      end else begin
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_out", 32'(out), 32'd0);
        checkOutput("idle_last", 32'(last), 32'd0);
        checkOutput("idle_ready", 32'(din_ready), 32'd1);
      end
      checkOutput("tx_count", 32'(tx_count), 32'(modelCount));
      if (endOfWord) modelCount = modelCount + 16'd1;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] lsbWord;
    int         r;
    total      = 0;
    bad        = 0;
    monOn      = 1'b0;
    modelCount = 16'h0000;
    R          = 1'b1;
    din        = 8'h00;
    din_valid  = 1'b0;
    din2       = 8'h00;
    valid2     = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(din_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(tx_count), 32'd0);
    checkOutput("rst_out2_idle", 32'(out2), 32'd1);
    #1 R = 1'b0;
    monOn = 1'b1;

    // LSB-first instance with a high idle level, checked directly.
    lsbWord = 8'h01;
    @(negedge clk);
    din2   = lsbWord;
    valid2 = 1'b1;
    #2 checkOutput("lsb_ready", 32'(ready2), 32'd1);
    @(negedge clk);
    valid2 = 1'b0;
    din2   = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      checkOutput("lsb_out", 32'(out2), 32'((lsbWord >> i) & 8'h01));
      checkOutput("lsb_last", 32'(last2), 32'(i == 7));
      checkOutput("lsb_busy", 32'(busy2), 32'd1);
      @(negedge clk);
    end
    checkOutput("lsb_idle_out", 32'(out2), 32'd1);
    checkOutput("lsb_idle_busy", 32'(busy2), 32'd0);
    checkOutput("lsb_count", 32'(count2), 32'd1);

    // Reset during bit 4 of 8'hA5 discards the word.
    applyStimulus(8'hA5);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    monOn = 1'b0;
    R     = 1'b1;
    #1;
    checkOutput("midrst_out", 32'(out), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_last", 32'(last), 32'd0);
    checkOutput("midrst_ready", 32'(din_ready), 32'd0);
    checkOutput("midrst_count", 32'(tx_count), 32'd0);
    expQ.delete();
    modelCount = 16'h0000;
    @(negedge clk);
    #1;
    R     = 1'b0;
    monOn = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(8'hA5);
    drain();
    checkOutput("single_count", 32'(tx_count), 32'd1);

    applyStimulus(8'h05);
    applyStimulus(8'hA0);
    drain();
    checkOutput("b2b_count", 32'(tx_count), 32'd3);

    // Stall: a held 8'hFF is replaced by 8'h81 before the handshake.
    applyStimulus(8'h00);
    @(negedge clk);
    din       = 8'hFF;
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(8'h81);
    drain();

    repeat (200) begin
      r = $urandom_range(0, 3);
      if (r == 0) idleCycles($urandom_range(1, 3));
      else        applyStimulus(8'($urandom));
    end
    drain();

    @(negedge clk);
    #1 force dut.count_q = 16'hFFFF;
    modelCount = 16'hFFFF;
    @(posedge clk);
    #1 release dut.count_q;
    applyStimulus(8'($urandom));
    drain();
    checkOutput("wrap_count", 32'(tx_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
